// File: rtl/led_pattern_capture_pkg.sv
// Shared types and constants for the LED pattern capture block.
// Contents: FSM state encoding, timer default, colour codes, duration limits.
package led_pattern_capture_pkg;

  localparam int unsigned MS_W    = 14;
  localparam int unsigned DUR_W   = 12;
  localparam int unsigned COL_W   = 3;
  localparam int unsigned NUM_SEG = 4;

  localparam logic [MS_W-1:0]  TERMINAL_CNT_1MS_DEF = 14'd11999;
  localparam logic [DUR_W-1:0] DUR_MAX              = 12'hFFF;

  localparam logic [COL_W-1:0] COL_OFF = 3'b000;
  localparam logic [COL_W-1:0] COL_R   = 3'b100;
  localparam logic [COL_W-1:0] COL_G   = 3'b010;
  localparam logic [COL_W-1:0] COL_B   = 3'b001;

  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    WAIT_EDGE = 4'b0010,
    MEASURE   = 4'b0100,
    DONE      = 4'b1000
  } state_e;

endpackage

// File: rtl/led_pattern_capture_if.sv
// Control and result bundle of the LED pattern capture block.
// master: arm/abort driver and result reader; slave: the capture block.
interface led_pattern_capture_if;
  import led_pattern_capture_pkg::*;

  logic             arm;
  logic             abort;
  logic [DUR_W-1:0] duration0;
  logic [DUR_W-1:0] duration1;
  logic [DUR_W-1:0] duration2;
  logic [DUR_W-1:0] duration3;
  logic [COL_W-1:0] color0;
  logic [COL_W-1:0] color1;
  logic [COL_W-1:0] color2;
  logic [COL_W-1:0] color3;
  logic             busy;
  logic             done;
  logic             timeout;

  modport master (
    output arm, abort,
    input  duration0, duration1, duration2, duration3,
    input  color0, color1, color2, color3,
    input  busy, done, timeout
  );

  modport slave (
    input  arm, abort,
    output duration0, duration1, duration2, duration3,
    output color0, color1, color2, color3,
    output busy, done, timeout
  );
endinterface

// File: rtl/led_pattern_capture_input_filter.sv
// Synchronizer plus glitch filter for the three colour pins.
// Ports: clk, rst (async, high), in_r/in_g/in_b (async pins),
//        color (filtered {r,g,b}), chg (one-cycle strobe on colour update).
module led_input_filter
  import led_pattern_capture_pkg::*;
#(
  parameter int unsigned GLITCH_CYC = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_r,
  input  logic             in_g,
  input  logic             in_b,
  output logic [COL_W-1:0] color,
  output logic             chg
);

  localparam int unsigned CNT_W = 8;

  logic [COL_W-1:0] sync1, sync2, cand;
  logic [CNT_W-1:0] run_q, run_c;
  logic             accept_c;

  // run_c = consecutive cycles sync2 has held its current value (capped)
  always_comb begin
    run_c = CNT_W'(1);
    if (sync2 == cand) begin
      run_c = (run_q == CNT_W'(GLITCH_CYC)) ? run_q : run_q + CNT_W'(1);
    end
    accept_c = (sync2 != color) && (run_c == CNT_W'(GLITCH_CYC));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= COL_OFF;
      sync2 <= COL_OFF;
      cand  <= COL_OFF;
      run_q <= '0;
      color <= COL_OFF;
      chg   <= 1'b0;
    end else begin
      sync1 <= {in_r, in_g, in_b};
      sync2 <= sync1;
      cand  <= sync2;
      run_q <= run_c;
      chg   <= accept_c;
      if (accept_c) color <= sync2;
    end
  end

endmodule

// File: rtl/led_pattern_capture.sv
// Captures up to four colour segments from external pins as colour/duration
// pairs in LED sequencer encoding (zero duration = unused slot).
// Ports: clk, rst (async, high), in_r/in_g/in_b (async pins),
//        bus (arm/abort in; duration0..3, color0..3, busy, done, timeout out).
module led_pattern_capture
  import led_pattern_capture_pkg::*;
#(
  parameter logic [MS_W-1:0] TERMINAL_CNT_1MS = TERMINAL_CNT_1MS_DEF,
  parameter int unsigned     GLITCH_CYC       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_r,
  input  logic                  in_g,
  input  logic                  in_b,
  led_pattern_capture_if.slave  bus
);

  logic [COL_W-1:0] fcol;
  logic             chg;

  led_input_filter #(.GLITCH_CYC(GLITCH_CYC)) u_filter (
    .clk   (clk),
    .rst   (rst),
    .in_r  (in_r),
    .in_g  (in_g),
    .in_b  (in_b),
    .color (fcol),
    .chg   (chg)
  );

  state_e           state_q, state_d;
  logic [MS_W-1:0]  ms_q;
  logic [DUR_W-1:0] seg_q;
  logic [1:0]       k_q, k_d;
  logic [DUR_W-1:0] dur_q [NUM_SEG];
  logic [DUR_W-1:0] dur_d [NUM_SEG];
  logic [COL_W-1:0] col_q [NUM_SEG];
  logic [COL_W-1:0] col_d [NUM_SEG];
  logic             timeout_q, timeout_d;
  logic             busy_q, done_q;
  logic             running_c, tick_c;

  assign running_c = (state_q == WAIT_EDGE) || (state_q == MEASURE);
  assign tick_c    = running_c && (ms_q == TERMINAL_CNT_1MS);

  // ms timer and segment counter; both restart on every accepted edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms_q  <= '0;
      seg_q <= '0;
    end else begin
      if (!running_c || chg || tick_c) ms_q <= '0;
      else                             ms_q <= ms_q + MS_W'(1);
      if (!running_c || chg)                seg_q <= '0;
      else if (tick_c && seg_q != DUR_MAX)  seg_q <= seg_q + DUR_W'(1);
    end
  end

  // Next state and result updates; abort overrides everything
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    dur_d     = dur_q;
    col_d     = col_q;
    timeout_d = timeout_q;
    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.arm) begin
            timeout_d = 1'b0;
            for (int i = 0; i < NUM_SEG; i++) begin
              dur_d[i] = '0;
              col_d[i] = COL_OFF;
            end
            state_d = WAIT_EDGE;
          end
        end
        WAIT_EDGE: begin
          if (chg) begin
            k_d      = 2'd0;
            col_d[0] = fcol;
            state_d  = MEASURE;
          end
        end
        MEASURE: begin
          // chg beats a coincident tick: the tick is not counted
          if (chg) begin
            dur_d[k_q] = (seg_q == '0) ? DUR_W'(1) : seg_q;
            if (k_q == 2'd3 || (k_q != 2'd0 && fcol == col_q[0])) begin
              state_d = DONE;
            end else begin
              k_d                = k_q + 2'd1;
              col_d[k_q + 2'd1]  = fcol;
            end
          end else if (tick_c && seg_q == DUR_MAX) begin
            dur_d[k_q] = DUR_MAX;
            timeout_d  = 1'b1;
            state_d    = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      for (int i = 0; i < NUM_SEG; i++) begin
        dur_q[i] <= '0;
        col_q[i] <= COL_OFF;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      timeout_q <= timeout_d;
      busy_q    <= (state_d == WAIT_EDGE) || (state_d == MEASURE);
      done_q    <= (state_d == DONE);
      dur_q     <= dur_d;
      col_q     <= col_d;
    end
  end

  assign bus.duration0 = dur_q[0];
  assign bus.duration1 = dur_q[1];
  assign bus.duration2 = dur_q[2];
  assign bus.duration3 = dur_q[3];
  assign bus.color0    = col_q[0];
  assign bus.color1    = col_q[1];
  assign bus.color2    = col_q[2];
  assign bus.color3    = col_q[3];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_led_pattern_capture.sv
// Scoreboard bench for led_pattern_capture with a shortened 1 ms tick
// (10 cycles) and GLITCH_CYC=4 so that a 4095 ms timeout stays short.
module tb_led_pattern_capture;

  localparam int P = 10;  // cycles per ms in this bench

  typedef struct packed {
    logic [3:0][11:0] dur;
    logic [3:0][2:0]  col;
    logic             to;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_r = 1'b0, in_g = 1'b0, in_b = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [11:0] gd [4];
  logic [2:0]  gc [4];

  always #5 clk = ~clk;

  led_pattern_capture_if bus();

  led_pattern_capture #(.TERMINAL_CNT_1MS(14'd9), .GLITCH_CYC(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .in_r (in_r),
    .in_g (in_g),
    .in_b (in_b),
    .bus  (bus)
  );

  assign gd[0] = bus.duration0;
  assign gd[1] = bus.duration1;
  assign gd[2] = bus.duration2;
  assign gd[3] = bus.duration3;
  assign gc[0] = bus.color0;
  assign gc[1] = bus.color1;
  assign gc[2] = bus.color2;
  assign gc[3] = bus.color3;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic push_exp(input logic [11:0] d0, d1, d2, d3,
                          input logic [2:0] c0, c1, c2, c3, input logic to);
    exp_t e;
    e.dur[0] = d0; e.dur[1] = d1; e.dur[2] = d2; e.dur[3] = d3;
    e.col[0] = c0; e.col[1] = c1; e.col[2] = c2; e.col[3] = c3;
    e.to = to;
    exp_q.push_back(e);
  endtask

  task automatic set_col(input logic [2:0] c);
    {in_r, in_g, in_b} = c;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic arm_pulse();
    bus.arm = 1'b1;
    @(negedge clk);
    bus.arm = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (bus.done !== 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(bus.done), 32'd1);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("busy_after_done", 32'(bus.busy), 32'd0);
  endtask

  // Idle with pins OFF long enough for the filter to settle
  task automatic settle();
    set_col(3'b000);
    cyc(20);
  endtask

  // Monitor: every done pulse is compared against the oldest expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 required no pending capture");
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 4; i++) begin
            check($sformatf("duration%0d", i), 32'(gd[i]), 32'(e.dur[i]));
            check($sformatf("color%0d", i), 32'(gc[i]), 32'(e.col[i]));
          end
          check("timeout", 32'(bus.timeout), 32'(e.to));
        end
      end
    end
  end

  initial begin : watchdog
    #(600_000 * 10);
    $display("FAIL watchdog: got no end of test required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.arm   = 1'b0;
    bus.abort = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_timeout", 32'(bus.timeout), 32'd0);
    check("rst_duration0", 32'(bus.duration0), 32'd0);
    check("rst_color0", 32'(bus.color0), 32'd0);
    cyc(3);
    rst = 1'b0;
    settle();

    // Two-colour blink; a second arm mid-capture must be ignored.
    // Segments carry half a ms of slack so no tick coincides with the edge.
    push_exp(12'd100, 12'd50, 12'd0, 12'd0, 3'b100, 3'b000, 3'b000, 3'b000, 1'b0);
    arm_pulse();
    check("busy_after_arm", 32'(bus.busy), 32'd1);
    set_col(3'b100);
    cyc(50 * P);
    arm_pulse();
    cyc(50 * P + P / 2 - 1);
    set_col(3'b000);
    cyc(50 * P + P / 2);
    set_col(3'b100);
    wait_done(100);
    settle();

    // Four segments ending on the fourth edge
    push_exp(12'd10, 12'd20, 12'd30, 12'd40, 3'b100, 3'b010, 3'b001, 3'b110, 1'b0);
    arm_pulse();
    set_col(3'b100); cyc(10 * P + P / 2);
    set_col(3'b010); cyc(20 * P + P / 2);
    set_col(3'b001); cyc(30 * P + P / 2);
    set_col(3'b110); cyc(40 * P + P / 2);
    set_col(3'b000);
    wait_done(100);
    settle();

    // Glitch rejection: 3-cycle R inside G is dropped; 8-cycle R is a sub-ms segment
    push_exp(12'd50, 12'd1, 12'd0, 12'd0, 3'b010, 3'b100, 3'b000, 3'b000, 1'b0);
    arm_pulse();
    set_col(3'b010); cyc(20 * P);
    set_col(3'b100); cyc(3);
    set_col(3'b010); cyc(30 * P + P / 2 - 3);
    set_col(3'b100); cyc(8);
    set_col(3'b010);
    wait_done(100);
    settle();

    // Exact whole-ms segments: the tick coinciding with the edge is excluded
    push_exp(12'd29, 12'd19, 12'd0, 12'd0, 3'b100, 3'b000, 3'b000, 3'b000, 1'b0);
    arm_pulse();
    set_col(3'b100); cyc(30 * P);
    set_col(3'b000); cyc(20 * P);
    set_col(3'b100);
    wait_done(100);
    settle();

    // Timeout: B held past 4095 ms saturates slot 0
    push_exp(12'd4095, 12'd0, 12'd0, 12'd0, 3'b001, 3'b000, 3'b000, 3'b000, 1'b1);
    arm_pulse();
    set_col(3'b001);
    wait_done(4200 * P);
    check("timeout_sticky", 32'(bus.timeout), 32'd1);
    settle();

    // Abort after the first segment: no done, slot 0 kept
    arm_pulse();
    check("timeout_cleared_by_arm", 32'(bus.timeout), 32'd0);
    set_col(3'b100); cyc(10 * P + P / 2);
    set_col(3'b010); cyc(3 * P);
    check("busy_before_abort", 32'(bus.busy), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("busy_after_abort", 32'(bus.busy), 32'd0);
    check("abort_duration0", 32'(bus.duration0), 32'd10);
    check("abort_duration1", 32'(bus.duration1), 32'd0);
    check("abort_color0", 32'(bus.color0), 32'd4);
    check("abort_color1", 32'(bus.color1), 32'd2);
    cyc(5 * P);

    // A new arm clears the previous results
    arm_pulse();
    check("rearm_duration0", 32'(bus.duration0), 32'd0);
    check("rearm_color1", 32'(bus.color1), 32'd0);
    check("rearm_busy", 32'(bus.busy), 32'd1);
    set_col(3'b100); cyc(5 * P + P / 2);
    set_col(3'b001); cyc(2 * P);
    check("pre_rst_duration0", 32'(bus.duration0), 32'd5);

    // Async reset mid-MEASURE clears outputs before any clock edge
    #2 rst = 1'b1;
    #1;
    check("async_rst_duration0", 32'(bus.duration0), 32'd0);
    check("async_rst_color0", 32'(bus.color0), 32'd0);
    check("async_rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    settle();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
